// File: rtl/dfdd_stream_pkg.sv
// -----------------------------------------------------------------------------
// dfdd_stream_pkg
// Shared types for the dual camera stream aligner.
//   state_t     : aligner FSM states (SYNC = hunting for a common sof,
//                 STREAM = emitting lock-stepped pixel pairs)
//   PIX_W       : camera pixel width
//   fifo_word_t : one buffered input beat {sof, pixel}
// -----------------------------------------------------------------------------
package dfdd_stream_pkg;

  localparam int PIX_W = 8;

  typedef enum logic {
    SYNC   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] pix;
  } fifo_word_t;

endpackage

// File: rtl/dfdd_stream_aligner_fifo.sv
// -----------------------------------------------------------------------------
// sync_fwft_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// data_o whenever empty_o is low; pop_i consumes it.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, data_i : write request and data (ignored when full unless a pop
//                    happens in the same cycle)
//   pop_i          : consume the head entry (ignored when empty)
//   data_o         : head entry
//   full_o, empty_o: occupancy flags
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 4.
// -----------------------------------------------------------------------------
module sync_fwft_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A write into a full FIFO is accepted only when the head leaves in the same
  // cycle, so occupancy stays put.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dfdd_stream_aligner.sv
// -----------------------------------------------------------------------------
// dfdd_stream_aligner
// Buffers two independent uint8 camera streams (A = I rho-plus,
// B = I rho-minus), aligns them on start-of-frame and emits lock-stepped
// pixel pairs with raster col/row coordinates. The output side has no
// backpressure.
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   a_pixel_i/a_sof_i/a_valid_i    : stream A beat, a_ready_o = FIFO A not full
//   b_pixel_i/b_sof_i/b_valid_i    : stream B beat, b_ready_o = FIFO B not full
//   i_rho_plus_uint8_o             : aligned A pixel
//   i_rho_minus_uint8_o            : aligned B pixel
//   col_o, row_o                   : coordinates of the emitted pair
//   valid_o                        : pair strobe (outputs hold when low)
//   frame_err_o                    : sticky misalignment flag
//   frame_cnt_o                    : completed frames, wraps at 2^16
// -----------------------------------------------------------------------------
module dfdd_stream_aligner
  import dfdd_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 400,
  parameter int FIFO_DEPTH   = 16,
  parameter int COORD_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [PIX_W-1:0]       a_pixel_i,
  input  logic                   a_sof_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [PIX_W-1:0]       b_pixel_i,
  input  logic                   b_sof_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic [PIX_W-1:0]       i_rho_plus_uint8_o,
  output logic [PIX_W-1:0]       i_rho_minus_uint8_o,
  output logic [COORD_WIDTH-1:0] col_o,
  output logic [COORD_WIDTH-1:0] row_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic [15:0]            frame_cnt_o
);

  localparam logic [COORD_WIDTH-1:0] COL_LAST  = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_LAST  = COORD_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
  localparam int                     WORD_W    = $bits(fifo_word_t);

  // ---------------------------------------------------------------------------
  // Input FIFOs
  // ---------------------------------------------------------------------------
  fifo_word_t a_head, b_head;
  logic       a_full, a_empty, b_full, b_empty;
  logic       a_push, b_push, a_pop, b_pop;
  logic       ready_en_q, ready_en_d;

  // Readies are held low through reset and rise on the first edge after
  // release, independent of the (already empty) FIFO flags.
  assign ready_en_d = 1'b1;
  assign a_ready_o  = ready_en_q && !a_full;
  assign b_ready_o  = ready_en_q && !b_full;
  assign a_push     = a_valid_i && a_ready_o;
  assign b_push     = b_valid_i && b_ready_o;

  sync_fwft_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (a_push),
    .data_i  ({a_sof_i, a_pixel_i}),
    .pop_i   (a_pop),
    .data_o  (a_head),
    .full_o  (a_full),
    .empty_o (a_empty)
  );

  sync_fwft_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (b_push),
    .data_i  ({b_sof_i, b_pixel_i}),
    .pop_i   (b_pop),
    .data_o  (b_head),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  // ---------------------------------------------------------------------------
  // FSM, coordinate counters and output register
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [PIX_W-1:0]       plus_q, plus_d, minus_q, minus_d;
  logic [COORD_WIDTH-1:0] col_out_q, col_out_d, row_out_q, row_out_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   both_avail, exp_sof;

  assign both_avail = !a_empty && !b_empty;
  assign exp_sof    = (col_q == '0) && (row_q == '0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    a_pop       = 1'b0;
    b_pop       = 1'b0;
    plus_d      = plus_q;
    minus_d     = minus_q;
    col_out_d   = col_out_q;
    row_out_d   = row_out_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      SYNC: begin
        // Discard anything ahead of a frame start; an sof head waits for the
        // other stream's sof.
        a_pop = !a_empty && !a_head.sof;
        b_pop = !b_empty && !b_head.sof;
        if (both_avail && a_head.sof && b_head.sof) state_d = STREAM;
      end
      STREAM: begin
        if (both_avail) begin
          if ((a_head.sof == exp_sof) && (b_head.sof == exp_sof)) begin
            a_pop     = 1'b1;
            b_pop     = 1'b1;
            valid_d   = 1'b1;
            plus_d    = a_head.pix;
            minus_d   = b_head.pix;
            col_out_d = col_q;
            row_out_d = row_q;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
              end else begin
                row_d = row_q + COORD_ONE;
              end
            end else begin
              col_d = col_q + COORD_ONE;
            end
          end else begin
            // Leave the offending heads in place: an sof head is exactly what
            // SYNC needs to re-acquire the next frame without losing it.
            err_d   = 1'b1;
            col_d   = '0;
            row_d   = '0;
            state_d = SYNC;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= SYNC;
      ready_en_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      plus_q      <= '0;
      minus_q     <= '0;
      col_out_q   <= '0;
      row_out_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      col_q       <= col_d;
      row_q       <= row_d;
      plus_q      <= plus_d;
      minus_q     <= minus_d;
      col_out_q   <= col_out_d;
      row_out_q   <= row_out_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign i_rho_plus_uint8_o  = plus_q;
  assign i_rho_minus_uint8_o = minus_q;
  assign col_o               = col_out_q;
  assign row_o               = row_out_q;
  assign valid_o             = valid_q;
  assign frame_err_o         = err_q;
  assign frame_cnt_o         = frame_cnt_q;

endmodule
